// File: rtl/serial_add_seq_if.sv
// Handshake and full-adder-cell bundle for serial_add_seq.
// The slave modport is the sequencer. The master modport is the requester, which also hosts the cell.
interface serial_add_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;

   modport slave (
      input  start, a, b, cin, fa_sum, fa_cout,
      output busy, done, sum, cout, fa_a, fa_b, fa_cin
   );

   modport master (
      output start, a, b, cin, fa_sum, fa_cout,
      input  busy, done, sum, cout, fa_a, fa_b, fa_cin
   );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder sequencer around an external combinational 1-bit full-adder cell.
// Operands go to the cell LSB first, one bit per cycle. The result comes back with a one-cycle done pulse.
module serial_add_seq #(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   serial_add_seq_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [WIDTH-1:0] res_shifted;

   // The new sum bit enters at the MSB, so after WIDTH shifts bit 0 has reached position 0.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_shifted = bus.fa_sum;
      end else begin : g_res_wn
         assign res_shifted = {bus.fa_sum, res_sh_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            res_sh_d = res_shifted;
            carry_d  = bus.fa_cout;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               sum_d   = res_shifted;
               cout_d  = bus.fa_cout;
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
      end
   end

   // The cell inputs are forced to zero outside SHIFT so that the cell sees no activity while idle.
   assign bus.fa_a   = (state_q == S_SHIFT) & a_sh_q[0];
   assign bus.fa_b   = (state_q == S_SHIFT) & b_sh_q[0];
   assign bus.fa_cin = (state_q == S_SHIFT) & carry_q;
   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = (state_q == S_DONE);
   assign bus.sum    = sum_q;
   assign bus.cout   = cout_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and random self-check of serial_add_seq at WIDTH=8 and WIDTH=1.
// A behavioural full-adder cell is attached to each instance.
module tb_serial_add_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] prev_sum8;
   logic       prev_cout8;

   always #5 clk = ~clk;

   serial_add_seq_if #(.WIDTH(8)) bus8 ();
   serial_add_seq_if #(.WIDTH(1)) bus1 ();

   assign bus8.fa_sum  = bus8.fa_a ^ bus8.fa_b ^ bus8.fa_cin;
   assign bus8.fa_cout = (bus8.fa_a & bus8.fa_b) | (bus8.fa_a & bus8.fa_cin) | (bus8.fa_b & bus8.fa_cin);
   assign bus1.fa_sum  = bus1.fa_a ^ bus1.fa_b ^ bus1.fa_cin;
   assign bus1.fa_cout = (bus1.fa_a & bus1.fa_b) | (bus1.fa_a & bus1.fa_cin) | (bus1.fa_b & bus1.fa_cin);

   serial_add_seq #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_add_seq #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete WIDTH=8 operation with cycle-exact checks on done, busy and the result.
   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic [7:0] es, input logic ec);
      int busy_n;
      int done_n;
      busy_n = 0;
      done_n = 0;
      bus8.a     = av;
      bus8.b     = bv;
      bus8.cin   = cv;
      bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (bus8.busy) busy_n++;
         if (i == 4) check({tag, "_hold"}, {23'd0, bus8.cout, bus8.sum}, {23'd0, prev_cout8, prev_sum8});
         tick();
         if (bus8.done) done_n++;
      end
      if (bus8.busy) busy_n++;
      check({tag, "_done"}, {31'd0, bus8.done}, 32'd1);
      check({tag, "_sum"}, {24'd0, bus8.sum}, {24'd0, es});
      check({tag, "_cout"}, {31'd0, bus8.cout}, {31'd0, ec});
      tick();
      check({tag, "_done_end"}, {31'd0, bus8.done}, 32'd0);
      check({tag, "_busy_end"}, {31'd0, bus8.busy}, 32'd0);
      check({tag, "_busy_cycles"}, busy_n, 32'd9);
      check({tag, "_done_pulses"}, done_n, 32'd1);
      prev_sum8  = es;
      prev_cout8 = ec;
   endtask

   initial begin
      logic [8:0] full;
      logic [7:0] ra, rb;
      logic       rc;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
      prev_sum8 = 8'd0;
      prev_cout8 = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_busy", {31'd0, bus8.busy}, 32'd0);
      check("rst_done", {31'd0, bus8.done}, 32'd0);
      check("rst_sum_cout", {23'd0, bus8.cout, bus8.sum}, 32'd0);
      check("rst_fa", {29'd0, bus8.fa_a, bus8.fa_b, bus8.fa_cin}, 32'd0);
      rst = 1'b0;
      tick();

      run_op("basic", 8'h03, 8'h05, 1'b0, 8'h08, 1'b0);
      run_op("ripple1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_op("ripple2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

      // start is held for the whole operation and the operands change mid-op
      bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
      tick();
      for (int i = 1; i <= 8; i++) begin
         if (i == 3) begin
            bus8.a = 8'hAA;
            bus8.b = 8'h55;
         end
         tick();
      end
      check("hold_done", {31'd0, bus8.done}, 32'd1);
      check("hold_sum", {23'd0, bus8.cout, bus8.sum}, 32'h030);
      tick();
      check("hold_idle_e9", {31'd0, bus8.busy}, 32'd0);
      tick();
      check("hold_accept_e10", {31'd0, bus8.busy}, 32'd1);
      bus8.start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("hold_second_done", {31'd0, bus8.done}, 32'd1);
      check("hold_second_sum", {23'd0, bus8.cout, bus8.sum}, 32'h0FF);
      tick();
      prev_sum8 = 8'hFF;
      prev_cout8 = 1'b0;

      // Reset is applied while bit 4 is being presented
      bus8.a = 8'h0F; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("mid_busy_before", {31'd0, bus8.busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, bus8.busy}, 32'd0);
      check("mid_rst_done", {31'd0, bus8.done}, 32'd0);
      check("mid_rst_sum_cout", {23'd0, bus8.cout, bus8.sum}, 32'd0);
      check("mid_rst_fa", {29'd0, bus8.fa_a, bus8.fa_b, bus8.fa_cin}, 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("mid_no_done", {31'd0, bus8.done}, 32'd0);
      end
      prev_sum8 = 8'd0;
      prev_cout8 = 1'b0;
      run_op("after_rst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

      // WIDTH=1 instance
      check("w1_idle_fa", {29'd0, bus1.fa_a, bus1.fa_b, bus1.fa_cin}, 32'd0);
      bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      check("w1_shift_busy", {31'd0, bus1.busy}, 32'd1);
      check("w1_shift_done", {31'd0, bus1.done}, 32'd0);
      check("w1_shift_fa", {29'd0, bus1.fa_a, bus1.fa_b, bus1.fa_cin}, 32'd7);
      tick();
      check("w1_done", {31'd0, bus1.done}, 32'd1);
      check("w1_result", {30'd0, bus1.cout, bus1.sum}, 32'd3);
      check("w1_done_fa", {29'd0, bus1.fa_a, bus1.fa_b, bus1.fa_cin}, 32'd0);
      tick();
      check("w1_idle_done", {31'd0, bus1.done}, 32'd0);
      check("w1_idle_fa2", {29'd0, bus1.fa_a, bus1.fa_b, bus1.fa_cin}, 32'd0);

      // Random operands are checked against a+b+cin, and the result must stay stable between operations.
      for (int n = 0; n < 200; n++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         run_op("rand", ra, rb, rc, full[7:0], full[8]);
         tick();
         check("rand_stable", {23'd0, bus8.cout, bus8.sum}, {23'd0, full});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
